// File: rtl/alu_pkg.sv
// Shared ALU definitions: NZCV flag bit positions, condition-code values and
// the flag-stage shadow FSM encoding.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic {
        RUN   = 1'b0,
        SAVED = 1'b1
    } shadow_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator over an NZCV flag vector; shared
// with the branch unit.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (Cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register with same-cycle bypass into condition
// evaluation and a single-level shadow copy for exception save/restore.
module flag_cond_unit
    import alu_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] Flag_In,
    input  logic              S,
    input  logic              Valid_In,
    input  logic [3:0]        Cond,
    input  logic              Cond_Valid,
    input  logic              Save,
    input  logic              Restore,
    output logic [FLAG_W-1:0] Flags,
    output logic              Cond_Pass,
    output logic              Pass_Valid,
    output logic              Shadow_Valid,
    output logic              Err
);

    // Pass_Valid is Cond_Valid delayed by one edge with no back-pressure; the
    // consumer must take Cond_Pass in the cycle Pass_Valid is high.

    shadow_state_t     state;
    logic [FLAG_W-1:0] shadow;
    logic [FLAG_W-1:0] next_flags;
    logic              wr;
    logic              legal_restore;
    logic              legal_save;
    logic              err_next;
    logic              eval_pass;

    // Restore wins over Save when both are requested.
    assign wr            = Valid_In & S;
    assign legal_restore = Restore & (state == SAVED);
    assign legal_save    = Save & ~Restore & (state == RUN);
    assign err_next      = (Restore & (state == RUN)) |
                           (Save & ~Restore & (state == SAVED));

    always_comb begin
        next_flags = Flags;
        if (legal_restore)
            next_flags = shadow;
        else if (wr)
            next_flags = Flag_In;
    end

    cond_eval u_cond_eval (
        .Cond  (Cond),
        .flags (next_flags),
        .pass  (eval_pass)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            Flags      <= '0;
            shadow     <= '0;
            Cond_Pass  <= 1'b0;
            Pass_Valid <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Flags      <= next_flags;
            Pass_Valid <= Cond_Valid;
            Err        <= err_next;
            if (Cond_Valid)
                Cond_Pass <= eval_pass;
            // Shadow captures the pre-write flags even if wr fires this cycle.
            if (legal_save) begin
                shadow <= Flags;
                state  <= SAVED;
            end else if (legal_restore) begin
                state  <= RUN;
            end
        end
    end

    assign Shadow_Valid = (state == SAVED);

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: evaluation results go through an
// expected queue, register/FSM outputs are checked directly.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flag_in;
    logic       s;
    logic       valid_in;
    logic [3:0] cond;
    logic       cond_valid;
    logic       save;
    logic       restore;
    logic [3:0] flags;
    logic       cond_pass;
    logic       pass_valid;
    logic       shadow_valid;
    logic       err;

    logic [0:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;

    // Hand-derived pass masks; bit i is the result of condition code i.
    logic [3:0]  sweep_flags[6] = '{4'b0000, 4'b0100, 4'b1001, 4'b0010, 4'b1000, 4'b0011};
    logic [15:0] sweep_mask[6]  = '{16'h56AA, 16'h66A9, 16'h565A, 16'h55A6, 16'h6A9A, 16'h6966};

    always #5 clk = ~clk;

    flag_cond_unit #(.FLAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .Flag_In      (flag_in),
        .S            (s),
        .Valid_In     (valid_in),
        .Cond         (cond),
        .Cond_Valid   (cond_valid),
        .Save         (save),
        .Restore      (restore),
        .Flags        (flags),
        .Cond_Pass    (cond_pass),
        .Pass_Valid   (pass_valid),
        .Shadow_Valid (shadow_valid),
        .Err          (err)
    );

    // Monitor: pops one expectation for every Pass_Valid cycle.
    always @(negedge clk) begin
        if (!rst && pass_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL cond_pass_unexpected: Pass_Valid high with empty expected queue");
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                if (cond_pass !== e) begin
                    fails++;
                    $display("FAIL cond_pass: got %b expected %b at %0t", cond_pass, e, $time);
                end
            end
        end
    end

    task automatic idle_inputs();
        flag_in = 4'b0; s = 1'b0; valid_in = 1'b0; cond = 4'd0;
        cond_valid = 1'b0; save = 1'b0; restore = 1'b0;
    endtask

    // Apply one cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic [3:0] fi, input logic sv, input logic vi,
                       input logic [3:0] cd, input logic cv,
                       input logic sa, input logic rs);
        flag_in = fi; s = sv; valid_in = vi; cond = cd;
        cond_valid = cv; save = sa; restore = rs;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic eval(input logic [3:0] fi, input logic wr, input logic [3:0] cd,
                        input logic e);
        exp_q.push_back(e);
        cyc(fi, wr, wr, cd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset_flags", flags, 4'b0000);
        chk("reset_outs", {cond_pass, pass_valid, shadow_valid, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write and hold.
        cyc(4'b1000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("write_1000", flags, 4'b1000);
        cyc(4'b0100, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("hold_s_low", flags, 4'b1000);
        cyc(4'b0111, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("hold_valid_low", flags, 4'b1000);

        // Bypass of a same-cycle write into EQ.
        eval(4'b0100, 1'b1, 4'd0, 1'b1);
        chk("bypass_flags", flags, 4'b0100);
        chk("bypass_pv", {3'b0, pass_valid}, 4'b0001);
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("pass_hold", {2'b0, cond_pass, pass_valid}, 4'b0010);

        // Decode sweep: first code of each group uses the bypassed write.
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 16; c++) begin
                logic [15:0] m;
                m = sweep_mask[f];
                eval(sweep_flags[f], (c == 0), c[3:0], m[c]);
            end
            chk("sweep_flags", flags, sweep_flags[f]);
        end
        eval(4'b0110, 1'b1, 4'd8, 1'b0);   // HI with Z=C=1
        eval(4'b0110, 1'b0, 4'd9, 1'b1);   // LS

        // Legal save/restore with concurrent writes.
        cyc(4'b0010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4'b1100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("save_flags", flags, 4'b1100);
        chk("save_sv_err", {2'b0, shadow_valid, err}, 4'b0010);
        exp_q.push_back(1'b1);              // CS on the restored 0010
        cyc(4'b0001, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
        chk("restore_flags", flags, 4'b0010);
        chk("restore_sv_err", {2'b0, shadow_valid, err}, 4'b0000);

        // Restore in RUN: illegal, write still applies.
        cyc(4'b0101, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("ill_restore_flags", flags, 4'b0101);
        chk("ill_restore_err", {2'b0, shadow_valid, err}, 4'b0001);
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("err_one_cycle", {3'b0, err}, 4'b0000);

        // Nested save: illegal, shadow keeps 0101.
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("save2_sv", {2'b0, shadow_valid, err}, 4'b0010);
        cyc(4'b1111, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("nest_save_flags", flags, 4'b1111);
        chk("nest_save_err", {2'b0, shadow_valid, err}, 4'b0011);
        // Save+Restore together in SAVED acts as a legal restore.
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("both_restore_flags", flags, 4'b0101);
        chk("both_restore_sv_err", {2'b0, shadow_valid, err}, 4'b0000);
        // Save+Restore together in RUN acts as an illegal restore.
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("both_run_sv_err", {2'b0, shadow_valid, err}, 4'b0001);

        // Asynchronous reset mid-stream drops a pending Pass_Valid.
        cyc(4'b1010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'b0, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_state", {cond_pass, pass_valid, shadow_valid, flags[1]}, 4'b1111);
        rst = 1'b1;
        #1;
        chk("async_rst_flags", flags, 4'b0000);
        chk("async_rst_outs", {cond_pass, pass_valid, shadow_valid, err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_flags", flags, 4'b0000);
        chk("post_rst_sv", {2'b0, shadow_valid, err}, 4'b0000);
        // Restore after reset is illegal: shadow state was cleared.
        cyc(4'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_restore", {err, flags[2:0]}, 4'b1000);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected results never observed, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
